pm_bank: RTL and testbench



---
 rtl/pm_bank.sv | 155 +++++++++++++++
 tb/tb_pm_bank.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pm_bank.sv
// pm_bank: two-slot ping-pong bank collecting one trellis step of ACS results
// and streaming it in ascending state order, with optional metric normalisation.
`default_nettype none

module pm_bank #(
    parameter int PM_W    = 7,
    parameter int ADDR_W  = 2,
    parameter int ID_W    = 4,
    parameter int NORM_EN = 1
) (
    input  logic                   PM_clk,
    input  logic                   PM_rst,
    input  logic                   wr_en,
    output logic                   wr_ready,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [PM_W-1:0]        wr_pm,
    input  logic                   wr_dec,
    input  logic [ID_W-1:0]        wr_id,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [ADDR_W-1:0]      rd_addr,
    output logic [PM_W-1:0]        rd_pm,
    output logic                   rd_dec,
    output logic [ID_W-1:0]        rd_id,
    output logic                   rd_last,
    output logic                   rd_norm,
    output logic [(1<<ADDR_W)-1:0] dec_vec,
    output logic                   err_id,
    output logic                   err_ovf
);

    localparam int NS = 1 << ADDR_W;
    localparam logic [PM_W-1:0] HALF = {1'b1, {(PM_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_FREE     = 2'd0,
        S_FILLING  = 2'd1,
        S_FULL     = 2'd2,
        S_DRAINING = 2'd3
    } slot_state_t;

    slot_state_t       slot_state [2];
    logic [ID_W-1:0]   slot_id    [2];
    logic [NS-1:0]     slot_mask  [2];
    logic [PM_W-1:0]   slot_min   [2];
    logic              slot_norm  [2];
    logic [NS-1:0]     slot_dec   [2];
    logic [PM_W-1:0]   slot_pm    [2][NS];

    logic              wr_slot;
    logic              rd_slot;
    logic [ADDR_W-1:0] rd_ptr;

    logic              accept;
    logic              first_wr;
    logic              id_ok;
    logic              do_write;
    logic              commit;
    logic              rd_fire;
    logic [NS-1:0]     addr_bit;
    logic [NS-1:0]     new_mask;
    logic [PM_W-1:0]   base_min;
    logic [PM_W-1:0]   new_min;
    logic [PM_W-1:0]   cur_pm;

    always_comb begin
        wr_ready = (slot_state[wr_slot] == S_FREE) || (slot_state[wr_slot] == S_FILLING);
        accept   = wr_en && wr_ready;
        first_wr = (slot_state[wr_slot] == S_FREE);
        id_ok    = first_wr || (wr_id == slot_id[wr_slot]);
        do_write = accept && id_ok;

        addr_bit          = '0;
        addr_bit[wr_addr] = 1'b1;
        new_mask = (first_wr ? '0 : slot_mask[wr_slot]) | addr_bit;
        // A fresh step restarts the minimum, so stale data from the previous step never leaks in.
        base_min = first_wr ? '1 : slot_min[wr_slot];
        new_min  = (wr_pm < base_min) ? wr_pm : base_min;
        commit   = do_write && (&new_mask);

        rd_valid = (slot_state[rd_slot] == S_FULL) || (slot_state[rd_slot] == S_DRAINING);
        rd_fire  = rd_valid && rd_ready;
        rd_addr  = rd_ptr;
        rd_last  = (rd_ptr == {ADDR_W{1'b1}});
        rd_id    = slot_id[rd_slot];
        rd_norm  = slot_norm[rd_slot];
        dec_vec  = slot_dec[rd_slot];
        rd_dec   = dec_vec[rd_ptr];
        cur_pm   = slot_pm[rd_slot][rd_ptr];
        // Every stored metric is >= the committed minimum >= HALF, so subtracting HALF only clears the MSB.
        rd_pm    = rd_norm ? (cur_pm & ~HALF) : cur_pm;
    end

    always_ff @(posedge PM_clk or negedge PM_rst) begin
        if (!PM_rst) begin
            wr_slot <= 1'b0;
            rd_slot <= 1'b0;
            rd_ptr  <= '0;
            err_id  <= 1'b0;
            err_ovf <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                slot_state[s] <= S_FREE;
                slot_id[s]    <= '0;
                slot_mask[s]  <= '0;
                slot_min[s]   <= '1;
                slot_norm[s]  <= 1'b0;
                slot_dec[s]   <= '0;
                for (int a = 0; a < NS; a++) begin
                    slot_pm[s][a] <= '0;
                end
            end
        end else begin
            if (wr_en && !wr_ready) begin
                err_ovf <= 1'b1;
            end
            if (accept && !id_ok) begin
                err_id <= 1'b1;
            end

            // The write and read slots are never the same slot while both are active.
            if (do_write) begin
                slot_pm[wr_slot][wr_addr]  <= wr_pm;
                slot_dec[wr_slot][wr_addr] <= wr_dec;
                slot_mask[wr_slot]         <= new_mask;
                slot_min[wr_slot]          <= new_min;
                if (first_wr) begin
                    slot_id[wr_slot] <= wr_id;
                end
                if (commit) begin
                    slot_state[wr_slot] <= S_FULL;
                    slot_norm[wr_slot]  <= (NORM_EN != 0) && (new_min >= HALF);
                    wr_slot             <= ~wr_slot;
                end else begin
                    slot_state[wr_slot] <= S_FILLING;
                end
            end

            if (rd_fire) begin
                if (rd_last) begin
                    slot_state[rd_slot] <= S_FREE;
                    slot_mask[rd_slot]  <= '0;
                    slot_min[rd_slot]   <= '1;
                    rd_ptr              <= '0;
                    rd_slot             <= ~rd_slot;
                end else begin
                    slot_state[rd_slot] <= S_DRAINING;
                    rd_ptr              <= rd_ptr + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pm_bank.sv
// tb_pm_bank: directed-vector bench for pm_bank at default parameters.
`default_nettype none

module tb_pm_bank;

    logic       PM_clk;
    logic       PM_rst;
    logic       wr_en;
    logic       wr_ready;
    logic [1:0] wr_addr;
    logic [6:0] wr_pm;
    logic       wr_dec;
    logic [3:0] wr_id;
    logic       rd_valid;
    logic       rd_ready;
    logic [1:0] rd_addr;
    logic [6:0] rd_pm;
    logic       rd_dec;
    logic [3:0] rd_id;
    logic       rd_last;
    logic       rd_norm;
    logic [3:0] dec_vec;
    logic       err_id;
    logic       err_ovf;

    int vectors;
    int miscompares;

    pm_bank dut (
        .PM_clk   (PM_clk),
        .PM_rst   (PM_rst),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_pm    (wr_pm),
        .wr_dec   (wr_dec),
        .wr_id    (wr_id),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_addr  (rd_addr),
        .rd_pm    (rd_pm),
        .rd_dec   (rd_dec),
        .rd_id    (rd_id),
        .rd_last  (rd_last),
        .rd_norm  (rd_norm),
        .dec_vec  (dec_vec),
        .err_id   (err_id),
        .err_ovf  (err_ovf)
    );

    initial PM_clk = 1'b0;
    always #5 PM_clk = ~PM_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PM_clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [6:0] p, input logic d, input logic [3:0] id);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_pm   = p;
        wr_dec  = d;
        wr_id   = id;
        tick();
        wr_en   = 1'b0;
    endtask

    // Drains one full step; wr_exp < 0 skips the wr_ready check during the drain.
    task automatic drain(input string tag, input logic [3:0] id, input logic norm, input logic [3:0] dv,
                         input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                         input logic [6:0] p3, input int wr_exp);
        logic [6:0] exp_pm [4];
        exp_pm[0] = p0;
        exp_pm[1] = p1;
        exp_pm[2] = p2;
        exp_pm[3] = p3;
        check({tag, ".id"}, 32'(rd_id), 32'(id));
        check({tag, ".norm"}, 32'(rd_norm), 32'(norm));
        check({tag, ".dec_vec"}, 32'(dec_vec), 32'(dv));
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s.valid[%0d]", tag, i), 32'(rd_valid), 32'd1);
            check($sformatf("%s.addr[%0d]", tag, i), 32'(rd_addr), 32'(i));
            check($sformatf("%s.pm[%0d]", tag, i), 32'(rd_pm), 32'(exp_pm[i]));
            check($sformatf("%s.dec[%0d]", tag, i), 32'(rd_dec), 32'(dv[i]));
            check($sformatf("%s.last[%0d]", tag, i), 32'(rd_last), (i == 3) ? 32'd1 : 32'd0);
            if (wr_exp >= 0) begin
                check($sformatf("%s.wr_ready[%0d]", tag, i), 32'(wr_ready), 32'(wr_exp));
            end
            tick();
        end
        rd_ready = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        PM_rst   = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_pm    = '0;
        wr_dec   = 1'b0;
        wr_id    = '0;
        rd_ready = 1'b0;

        #3;
        check("rst.rd_valid", 32'(rd_valid), 32'd0);
        check("rst.wr_ready", 32'(wr_ready), 32'd1);
        check("rst.rd_pm", 32'(rd_pm), 32'd0);
        check("rst.rd_addr", 32'(rd_addr), 32'd0);
        check("rst.rd_last", 32'(rd_last), 32'd0);
        check("rst.dec_vec", 32'(dec_vec), 32'd0);
        check("rst.errs", 32'({err_id, err_ovf}), 32'd0);
        #9 PM_rst = 1'b1;
        tick();

        // Basic step: dec_vec bit i is the decision of state i -> 4'b1110.
        wr(2'd2, 7'd10, 1'b1, 4'd3);
        wr(2'd0, 7'd5, 1'b0, 4'd3);
        wr(2'd3, 7'd20, 1'b1, 4'd3);
        check("basic.pre_commit_valid", 32'(rd_valid), 32'd0);
        wr(2'd1, 7'd7, 1'b1, 4'd3);
        check("basic.post_commit_valid", 32'(rd_valid), 32'd1);
        drain("basic", 4'd3, 1'b0, 4'b1110, 7'd5, 7'd7, 7'd10, 7'd20, 1);
        check("basic.empty", 32'(rd_valid), 32'd0);

        // Normalisation: min 64 reaches the threshold.
        wr(2'd0, 7'd70, 1'b0, 4'd4);
        wr(2'd1, 7'd64, 1'b0, 4'd4);
        wr(2'd2, 7'd100, 1'b0, 4'd4);
        wr(2'd3, 7'd127, 1'b0, 4'd4);
        drain("norm", 4'd4, 1'b1, 4'b0000, 7'd6, 7'd0, 7'd36, 7'd63, -1);
        wr(2'd0, 7'd70, 1'b1, 4'd4);
        wr(2'd1, 7'd64, 1'b0, 4'd4);
        wr(2'd2, 7'd100, 1'b0, 4'd4);
        wr(2'd3, 7'd63, 1'b1, 4'd4);
        drain("nonorm", 4'd4, 1'b0, 4'b1001, 7'd70, 7'd64, 7'd100, 7'd63, -1);

        // Backpressure: both slots fill, third step is refused.
        for (int i = 0; i < 4; i++) wr(2'(i), 7'(i + 1), 1'b0, 4'd1);
        for (int i = 0; i < 4; i++) wr(2'(i), 7'(i + 11), 1'b1, 4'd2);
        check("bp.wr_ready", 32'(wr_ready), 32'd0);
        check("bp.err_ovf_before", 32'(err_ovf), 32'd0);
        wr(2'd0, 7'd99, 1'b0, 4'd3);
        check("bp.err_ovf", 32'(err_ovf), 32'd1);
        drain("bp1", 4'd1, 1'b0, 4'b0000, 7'd1, 7'd2, 7'd3, 7'd4, 0);
        check("bp.wr_ready_back", 32'(wr_ready), 32'd1);
        check("bp.second_valid", 32'(rd_valid), 32'd1);
        drain("bp2", 4'd2, 1'b0, 4'b1111, 7'd11, 7'd12, 7'd13, 7'd14, 1);
        check("bp.empty", 32'(rd_valid), 32'd0);

        // Id mismatch and overwrite.
        wr(2'd0, 7'd9, 1'b0, 4'd5);
        wr(2'd0, 7'd4, 1'b0, 4'd5);
        check("idm.err_id_before", 32'(err_id), 32'd0);
        wr(2'd1, 7'd50, 1'b1, 4'd6);
        check("idm.err_id", 32'(err_id), 32'd1);
        check("idm.no_commit", 32'(rd_valid), 32'd0);
        wr(2'd1, 7'd8, 1'b0, 4'd5);
        wr(2'd2, 7'd30, 1'b1, 4'd5);
        check("idm.partial", 32'(rd_valid), 32'd0);
        wr(2'd3, 7'd31, 1'b0, 4'd5);
        drain("idm", 4'd5, 1'b0, 4'b0100, 7'd4, 7'd8, 7'd30, 7'd31, -1);

        // Reset during a stalled drain with a partial fill pending.
        for (int i = 0; i < 4; i++) wr(2'(i), 7'(i + 40), 1'b1, 4'd7);
        wr(2'd0, 7'd1, 1'b0, 4'd8);
        wr(2'd1, 7'd2, 1'b0, 4'd8);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("mid.addr", 32'(rd_addr), 32'd1);
        #2 PM_rst = 1'b0;
        #1;
        check("mid.rd_valid", 32'(rd_valid), 32'd0);
        check("mid.wr_ready", 32'(wr_ready), 32'd1);
        check("mid.errs", 32'({err_id, err_ovf}), 32'd0);
        check("mid.rd_addr", 32'(rd_addr), 32'd0);
        check("mid.rd_pm", 32'(rd_pm), 32'd0);
        #3 PM_rst = 1'b1;
        tick();
        check("post.rd_valid", 32'(rd_valid), 32'd0);
        wr(2'd3, 7'd33, 1'b0, 4'd9);
        wr(2'd1, 7'd31, 1'b1, 4'd9);
        wr(2'd0, 7'd30, 1'b0, 4'd9);
        check("post.partial", 32'(rd_valid), 32'd0);
        wr(2'd2, 7'd32, 1'b1, 4'd9);
        drain("post", 4'd9, 1'b0, 4'b0110, 7'd30, 7'd31, 7'd32, 7'd33, 1);
        check("post.empty", 32'(rd_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
